// File: rtl/display_mux_4dig.sv
// Four-digit seven-segment scan driver: holds a packed BCD value, walks digits 0..3 every DIV cycles.
// Optional macro LEADING_ZERO_BLANK_EN disables anodes of leading-zero digits (digit 0 always shown).
module display_mux_4dig #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] num,
    input  logic        load,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic [1:0]  dig_sel,
    output logic        frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_v_q, pend_v_d;
    logic          wrap_q, wrap_d;
    logic [3:0]    bcd_q, bcd_d;
    logic [3:0]    an_q, an_d;
    logic [1:0]    dig_q, dig_d;
    logic          frame_q, frame_d;

    logic tick;
    logic frame_end;
    logic blank;

    assign tick      = (cnt_q == CNT_MAX);
    assign frame_end = tick && (idx_q == 2'd3);

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and everything to its left is zero.
    assign blank = (idx_q != 2'd0) && ((shadow_q >> {idx_q, 2'b00}) == 16'h0000);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        wrap_d    = frame_end;

        // Shadow only changes at the frame boundary so a scan never mixes two values.
        if (frame_end) begin
            pend_v_d = 1'b0;
            if (load) begin
                shadow_d = num;
            end else if (pend_v_q) begin
                shadow_d = pending_q;
            end
        end else if (load) begin
            pending_d = num;
            pend_v_d  = 1'b1;
        end

        dig_d   = idx_q;
        bcd_d   = shadow_q[{idx_q, 2'b00} +: 4];
        an_d    = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        frame_d = wrap_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            pending_q <= 16'h0000;
            pend_v_q  <= 1'b0;
            wrap_q    <= 1'b0;
            bcd_q     <= 4'h0;
            an_q      <= 4'b1111;
            dig_q     <= 2'd0;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            wrap_q    <= wrap_d;
            bcd_q     <= bcd_d;
            an_q      <= an_d;
            dig_q     <= dig_d;
            frame_q   <= frame_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign an         = an_q;
    assign dig_sel    = dig_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_display_mux_4dig.sv
// Bench for display_mux_4dig: DIV=4 and DIV=1 instances against a time-based reference model.
module tb_display_mux_4dig;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] num = 16'h0000;
    logic        load = 1'b0;

    logic [3:0] bcd4, an4, bcd1, an1;
    logic [1:0] dig4, dig1;
    logic       fd4, fd1;

    int errors = 0;
    int checks = 0;

    // Model state per instance: edges since reset, displayed value, pending value.
    int          m_div [2] = '{4, 1};
    int          m_t   [2];
    logic [15:0] m_sh  [2];
    logic [15:0] m_pd  [2];
    logic        m_pv  [2];

    display_mux_4dig #(.DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .num(num), .load(load),
        .bcd_out(bcd4), .an(an4), .dig_sel(dig4), .frame_done(fd4)
    );

    display_mux_4dig #(.DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .num(num), .load(load),
        .bcd_out(bcd1), .an(an1), .dig_sel(dig1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, obs, exp_v);
        end
    endtask

    // One clock: drive inputs on the falling edge, predict and check after the rising edge.
    task automatic step(input logic r, input logic l, input logic [15:0] n);
        logic [3:0]  e_bcd [2];
        logic [3:0]  e_an  [2];
        logic [1:0]  e_dig [2];
        logic        e_fd  [2];
        @(negedge clk);
        rst  = r;
        load = l;
        num  = n;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int  d, frame_len, digit;
            logic all_zero;
            d = m_div[k];
            frame_len = 4 * d;
            if (r) begin
                e_bcd[k] = 4'h0; e_an[k] = 4'b1111; e_dig[k] = 2'd0; e_fd[k] = 1'b0;
                m_t[k] = 0; m_sh[k] = 16'h0; m_pd[k] = 16'h0; m_pv[k] = 1'b0;
            end else begin
                digit = (m_t[k] / d) % 4;
                e_dig[k] = 2'(digit);
                e_bcd[k] = 4'((m_sh[k] >> (4 * digit)) & 16'hF);
                e_an[k]  = 4'hF ^ 4'(1 << digit);
                all_zero = 1'b1;
                for (int j = digit; j < 4; j++)
                    if (((m_sh[k] >> (4 * j)) & 16'hF) != 0) all_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                if (digit != 0 && all_zero) e_an[k] = 4'b1111;
`endif
                e_fd[k] = (m_t[k] > 0) && (m_t[k] % frame_len == 0);
                if (m_t[k] % frame_len == frame_len - 1) begin
                    if (l) m_sh[k] = n;
                    else if (m_pv[k]) m_sh[k] = m_pd[k];
                    m_pv[k] = 1'b0;
                end else if (l) begin
                    m_pd[k] = n;
                    m_pv[k] = 1'b1;
                end
                m_t[k]++;
            end
        end
        #1;
        chk("bcd4", 16'(bcd4), 16'(e_bcd[0]));
        chk("an4",  16'(an4),  16'(e_an[0]));
        chk("dig4", 16'(dig4), 16'(e_dig[0]));
        chk("fd4",  16'(fd4),  16'(e_fd[0]));
        chk("bcd1", 16'(bcd1), 16'(e_bcd[1]));
        chk("an1",  16'(an1),  16'(e_an[1]));
        chk("dig1", 16'(dig1), 16'(e_dig[1]));
        chk("fd1",  16'(fd1),  16'(e_fd[1]));
    endtask

    // Idle until the DIV=4 instance reaches a given position within its 16-cycle frame.
    task automatic idle_to_phase(input int ph);
        for (int i = 0; i < 20; i++) begin
            if (m_t[0] % 16 == ph) return;
            step(1'b0, 1'b0, 16'h0);
        end
        chk("phase_reach", 16'(m_t[0] % 16), 16'(ph));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0; m_sh[k] = 16'h0; m_pd[k] = 16'h0; m_pv[k] = 1'b0;
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h1234);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 16'h0);

        idle_to_phase(5);
        step(1'b0, 1'b1, 16'h5678);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 16'h0);

        idle_to_phase(6);
        step(1'b0, 1'b1, 16'h9876);
        idle_to_phase(15);
        step(1'b0, 1'b1, 16'h4321);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0);

        idle_to_phase(9);
        step(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0);

        step(1'b0, 1'b1, 16'h0042);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0500);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 1500; i++) begin
            logic        r, l;
            logic [15:0] n;
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       n = 16'($urandom_range(0, 255));
                1:       n = 16'h0000;
                default: n = 16'($urandom);
            endcase
            step(r, l, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_mux_4dig.md
Name: display_mux_4dig

Overview:
- Time-multiplexed driver for a 4-digit common-anode seven-segment display.
- Holds a 4-digit packed BCD value and scans one digit at a time.
- Presents the active digit's BCD nibble to the existing BCD-to-seven-segment decoder and drives the matching active-low anode.
- Sits directly upstream of the decoder; the decoder's segment output goes to the board pins.

Parameters:
- DIV, 50000: clock cycles per digit slot (refresh prescaler). Legal range DIV >= 1; use DIV=4 in simulation.
- CW, max(1, $clog2(DIV)): prescaler counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- num  in  16  packed BCD value; digit 3 = num[15:12] (leftmost), digit 0 = num[3:0].
- load  in  1  capture strobe for num, sampled on every rising edge.
- bcd_out  out  4  BCD nibble of the active digit; feeds the decoder's BCD input.
- an  out  4  anode enables, active-low; an[i] selects digit i.
- dig_sel  out  2  index of the active digit.
- frame_done  out  1  one-cycle pulse at the end of each full 4-digit scan.

Behaviour:
- Only the rst polarity and synchronicity and the clk edge are fixed. All state changes happen on the rising edge of clk.
- Reset (rst=1 at an edge), all registers cleared:
  - prescaler cnt=0, idx=0, shadow=16'h0000, pending=0, pend_v=0.
  - Outputs: an=4'b1111, bcd_out=4'h0, dig_sel=0, frame_done=0.
- Reset asserted mid-scan aborts the scan and discards any pending value. There is no partial frame.
- Prescaler:
  - cnt counts 0..DIV-1; tick = (cnt==DIV-1).
  - On tick: cnt <= 0 and idx <= idx+1 mod 4 (3 wraps to 0).
  - With DIV=1, tick is asserted every cycle.
- Outputs are registered from the current state, so they lag the state by 1 cycle:
  - dig_sel <= idx; bcd_out <= shadow[4*idx +: 4].
  - an <= ~(4'b0001 << idx).
  - First edge after reset release: an=4'b1110, bcd_out=shadow[3:0].
- Scan order is digit 0,1,2,3,0,... Each digit stays active exactly DIV cycles.
- Value capture, for tear-free display:
  - load=1 copies num into pending and sets pend_v.
  - At frame end (tick && idx==3), if pend_v: shadow <= pending and pend_v <= 0.
  - The new value is first shown in the digit-0 slot of the next frame.
  - load on the same edge as frame end: that edge's num goes straight to shadow and pend_v stays 0.
  - Multiple loads within one frame: the last one wins.
- frame_done is registered: it is 1 for exactly one cycle, coincident with the first output cycle of digit 0 after the wrap.
- Nibbles > 9 are passed to bcd_out unchanged; handling them is the decoder's job.
- No combinational path from any input to any output.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i (i=3,2,1) is blanked when shadow nibble i and every higher nibble equal 0. Digit 0 is never blanked.
  - A blanked slot keeps its full DIV-cycle timing but drives an=4'b1111, with bcd_out still showing the nibble (0).
  - Example: shadow=16'h0042 blanks digits 3 and 2; 16'h0000 shows only digit 0.
- Undefined: every digit is always enabled per the rules above.

Test Plan:
- Reset check (DIV=4): rst=1 for 3 cycles -> an=4'b1111, bcd_out=0, dig_sel=0, frame_done=0. On the first edge after release, an=4'b1110.
- Scan order (DIV=4): load 16'h1234 then wait 2 frames -> bcd_out sequence 4,3,2,1 with an 1110,1101,1011,0111, each held exactly 4 cycles. frame_done pulses once every 16 cycles.
- Tear-free update (DIV=4): shadow=16'h1234, load 16'h5678 during the digit-1 slot -> the remaining slots still show 2,1, then the next frame shows 8,7,6,5.
- Simultaneous events (DIV=4): load 16'h9876 with one value mid-frame and 16'h4321 on the exact frame-end edge -> the next frame shows 1,2,3,4; the earlier 16'h9876 value is never displayed.
- Mid-scan reset plus DIV=1: assert rst during the digit-2 slot -> the next output is an=1111, then the scan restarts at digit 0 with shadow=0. A separate DIV=1 instance advances the digit every cycle.
- LEADING_ZERO_BLANK_EN defined (DIV=4): load 16'h0042 -> digits 0,1 enabled showing 2,4; digits 2,3 slots give an=4'b1111. Load 16'h0000 -> only digit 0 enabled.
